fir_peak_monitor: RTL and testbench
===================================

FIR_PEAK_MONITOR -- requirements
Module: fir_peak_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 40, width of the signed filter output being monitored.
- SETTLE_CYCLES, 170, number of cycles input is ignored after start.
- WINDOW_CYCLES, 2000, number of compare cycles after the first captured sample.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request one measurement; sampled only in IDLE.
- din, in, DATA_W, signed fir_filter outp, sampled every cycle.
- busy, out, 1, high in SETTLE, MEASURE and DONE.
- done, out, 1, one-cycle pulse when a result is published.
- peak, out, DATA_W, signed maximum of the last completed window; held until the next done.
- meas_count, out, 8, number of completed measurements, modulo 256.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, SETTLE, MEASURE and DONE.
REQ-005 In IDLE, when start=1 at a rising edge, the FSM SHALL enter SETTLE and clear the cycle counter; otherwise it SHALL remain in IDLE.
REQ-006 SETTLE SHALL last exactly SETTLE_CYCLES cycles; din SHALL be ignored during SETTLE.
REQ-007 SETTLE_CYCLES=0 SHALL go directly to MEASURE.
REQ-008 In the first MEASURE cycle, the internal running maximum SHALL load din unconditionally.
REQ-009 In each of the next WINDOW_CYCLES cycles, the running maximum SHALL be replaced when din > running maximum (signed compare).
REQ-010 MEASURE SHALL last WINDOW_CYCLES+1 cycles, so exactly WINDOW_CYCLES+1 samples are considered.
REQ-011 Timing, with start accepted at edge 0:
- SETTLE occupies cycles 1..S.
- MEASURE occupies cycles S+1..S+W+1.
- DONE occupies cycle S+W+2.
- S=SETTLE_CYCLES, W=WINDOW_CYCLES.
REQ-012 On entry to DONE, the block SHALL register the running maximum (including the final sample) into peak and increment meas_count.
REQ-013 done SHALL be high exactly during the DONE cycle, and peak SHALL be valid in that same cycle.
REQ-014 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-015 start SHALL be ignored in SETTLE, MEASURE and DONE; it is neither queued nor able to restart the sequence.
REQ-016 Back-to-back measurements SHALL require start to be seen in IDLE, giving a minimum of one IDLE cycle between done and the next SETTLE.
REQ-017 Comparisons SHALL be full-width signed; a tie SHALL keep the stored value; no saturation or truncation.
REQ-018 meas_count SHALL wrap from 255 to 0 without any flag.
REQ-019 The cycle counter SHALL be $clog2(max(SETTLE_CYCLES, WINDOW_CYCLES)+1) bits wide and SHALL never overflow.

Reset
REQ-020 While rst_n=0, the block SHALL asynchronously hold the following values:
- state IDLE.
- busy=0, done=0.
- peak=0, meas_count=0.
- cycle counter and running maximum at 0.
REQ-021 A reset asserted in any state SHALL abort the measurement, publish no result and generate no done pulse.
REQ-022 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification (SETTLE_CYCLES=4, WINDOW_CYCLES=8 unless stated)
REQ-023 Basic timing: start pulse at edge 0, din ramps -5..+20 by 1 per cycle -> busy high cycles 1..14, done only at cycle 14, peak equals din sampled at cycle 13, meas_count=1.
REQ-024 Negative-only input: din held at -1000 with a single -3 at MEASURE cycle 5 -> peak=-3, confirming signed compare.
REQ-025 Settle exclusion: din=+10000 during SETTLE only and 0 afterwards -> peak=0.
REQ-026 Start while busy: start re-asserted during SETTLE, MEASURE and DONE -> no restart, exactly one done; a start in the cycle after done begins a new run.
REQ-027 Reset mid-run: rst_n pulsed low in MEASURE cycle 3 -> immediate IDLE, busy=0, peak=0, meas_count=0, no done.
REQ-028 Wrap and default params: run 256 measurements -> meas_count returns to 0; one run with default parameters and start at edge 0 -> done at cycle 2172.

Source files
------------

// File: rtl/fir_peak_monitor.sv
// Peak monitor for a signed FIR output: after a start request it ignores a settle period,
// then tracks the signed maximum over a fixed window and publishes it with a done pulse.
module fir_peak_monitor #(
    parameter int DATA_W        = 40,
    parameter int SETTLE_CYCLES = 170,
    parameter int WINDOW_CYCLES = 2000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] din,
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] peak,
    output logic [7:0]               meas_count
);

    localparam int MAX_CYC = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CNT_RAW = $clog2(MAX_CYC + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [CNT_W-1:0]           cnt_r;
    logic signed [DATA_W-1:0]   run_max_r;
    logic signed [DATA_W-1:0]   sample_max_s;
    logic signed [DATA_W-1:0]   peak_r;
    logic [7:0]                 meas_count_r;
    logic                       busy_r;
    logic                       done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_s = ST_MEASURE;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_MEASURE: begin
                if (cnt_r == WINDOW_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MEASURE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Running maximum including the current sample; first window cycle loads din outright.
    always_comb begin
        sample_max_s = run_max_r;
        if (cnt_r == CNT_ZERO) begin
            sample_max_s = din;
        end else if (din > run_max_r) begin
            sample_max_s = din;
        end else begin
            sample_max_s = run_max_r;
        end
    end

    // Cycle counter restarts at zero on every state change, so it never exceeds the window length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_s == state_r) &&
                     ((state_r == ST_SETTLE) || (state_r == ST_MEASURE))) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= CNT_ZERO;
        end
    end

    // Running maximum tracks only MEASURE samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_max_r <= '0;
        end else if (state_r == ST_MEASURE) begin
            run_max_r <= sample_max_s;
        end else begin
            run_max_r <= run_max_r;
        end
    end

    // Result publication and status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_r       <= '0;
            meas_count_r <= 8'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            if ((state_r == ST_MEASURE) && (state_s == ST_DONE)) begin
                peak_r       <= sample_max_s;
                meas_count_r <= meas_count_r + 8'd1;
            end else begin
                peak_r       <= peak_r;
                meas_count_r <= meas_count_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign peak       = peak_r;
    assign meas_count = meas_count_r;

endmodule

// File: tb/tb_fir_peak_monitor.sv
// Directed and randomized bench for fir_peak_monitor against a cycle-numbered reference model
// (small instance S=4/W=8 checked every cycle, default instance checked for one run).
module tb_fir_peak_monitor;

    localparam int S_P = 4;
    localparam int W_P = 8;
    localparam int RUN_LEN = S_P + W_P + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_d;
    logic [39:0] din;
    logic        busy, done, busy_d, done_d;
    logic [39:0] peak, peak_d;
    logic [7:0]  meas_count, cnt_d;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int          cyc = 0;
    int          run_e = 0;
    bit          run_valid = 1'b0;
    logic [39:0] win_q[$];
    logic [39:0] m_peak = 40'd0;
    logic [7:0]  m_count = 8'd0;
    int          ndone = 0;

    always #5 clk = ~clk;

    fir_peak_monitor #(.DATA_W(40), .SETTLE_CYCLES(S_P), .WINDOW_CYCLES(W_P)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din),
        .busy(busy), .done(done), .peak(peak), .meas_count(meas_count)
    );

    fir_peak_monitor dut_dflt (
        .clk(clk), .rst_n(rst_n), .start(start_d), .din(din),
        .busy(busy_d), .done(done_d), .peak(peak_d), .meas_count(cnt_d)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [39:0] qmax(input logic [39:0] q[$]);
        logic signed [39:0] m;
        m = q[0];
        foreach (q[i]) if ($signed(q[i]) > m) m = q[i];
        return m;
    endfunction

    function automatic logic [39:0] rnd40();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        if (t[63:62] == 2'b00) return 40'(t[3:0]);
        return t[39:0];
    endfunction

    // Checks the current cycle (spec numbering: cycle 1 follows the accepting edge), then drives it.
    task automatic tick(input logic st, input logic [39:0] d);
        int   sc;
        logic eb, ed;
        sc = run_valid ? (cyc - run_e + 1) : 0;
        eb = run_valid && (sc >= 1) && (sc <= RUN_LEN);
        ed = run_valid && (sc == RUN_LEN);
        if (ed) begin
            m_peak  = qmax(win_q);
            m_count = m_count + 8'd1;
        end
        if (done === 1'b1) ndone++;
        chk("busy", 40'(busy), 40'(eb));
        chk("done", 40'(done), 40'(ed));
        chk("peak", peak, m_peak);
        chk("meas_count", 40'(meas_count), 40'(m_count));
        start = st;
        din   = d;
        if (eb && (sc >= S_P + 1) && (sc <= S_P + W_P + 1)) win_q.push_back(d);
        if (!eb && st) begin
            run_valid = 1'b1;
            run_e     = cyc + 1;
            win_q.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int               done_at;
        int               e_d;
        int               seen;
        logic signed [39:0] dmax;
        logic [39:0]      d;

        rst_n = 1'b0; start = 1'b0; start_d = 1'b0; din = 40'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 40'(busy), 40'd0);
        chk("rst_done", 40'(done), 40'd0);
        chk("rst_peak", peak, 40'd0);
        chk("rst_count", 40'(meas_count), 40'd0);
        rst_n = 1'b1;
        tick(1'b0, 40'd0);
        tick(1'b0, 40'd0);

        // Basic timing with a ramp: peak is the din of cycle 13.
        done_at = -1;
        tick(1'b1, -40'sd5);
        for (int c = 1; c <= 16; c++) begin
            if (done === 1'b1) done_at = c;
            tick(1'b0, 40'(-5 + c));
        end
        chk("ramp_done_cycle", 40'(done_at), 40'd14);
        chk("ramp_peak", peak, 40'd8);
        chk("ramp_count", 40'(meas_count), 40'd1);

        // Negative-only input with one -3 in MEASURE cycle 5.
        tick(1'b1, -40'sd1000);
        for (int c = 1; c <= 15; c++)
            tick(1'b0, (c == S_P + 5) ? -40'sd3 : -40'sd1000);
        chk("neg_peak", peak, -40'sd3);

        // Large values during SETTLE only must not reach the result.
        tick(1'b1, 40'd0);
        for (int c = 1; c <= 15; c++)
            tick(1'b0, ((c >= 1) && (c <= S_P)) ? 40'd10000 : 40'd0);
        chk("settle_peak", peak, 40'd0);

        // start held through the whole run, then in the idle cycle right after done.
        ndone = 0;
        tick(1'b1, rnd40());
        for (int c = 1; c <= RUN_LEN; c++) tick(1'b1, rnd40());
        chk("busy_start_one_done", 40'(ndone), 40'd1);
        tick(1'b1, rnd40());
        for (int c = 1; c <= RUN_LEN + 1; c++) tick(1'b0, rnd40());
        chk("restart_two_done", 40'(ndone), 40'd2);

        // Randomized runs with spurious starts while busy and idle gaps.
        for (int r = 0; r < 12; r++) begin
            tick(1'b1, rnd40());
            for (int c = 1; c <= RUN_LEN; c++) tick(1'($urandom_range(0, 1)), rnd40());
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick(1'b0, rnd40());
        end

        // Reset in MEASURE cycle 3 aborts everything.
        tick(1'b1, rnd40());
        for (int c = 1; c <= S_P + 2; c++) tick(1'b0, rnd40());
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 40'(busy), 40'd0);
        chk("midrst_done", 40'(done), 40'd0);
        chk("midrst_peak", peak, 40'd0);
        chk("midrst_count", 40'(meas_count), 40'd0);
        run_valid = 1'b0; m_peak = 40'd0; m_count = 8'd0; win_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < RUN_LEN + 2; c++) tick(1'b0, rnd40());
        chk("midrst_no_done", 40'(ndone), 40'd0);

        // 256 back-to-back measurements wrap the counter to zero.
        for (int r = 0; r < 256; r++) begin
            tick(1'b1, rnd40());
            for (int c = 1; c <= RUN_LEN; c++) tick(1'b0, rnd40());
        end
        chk("wrap_count", 40'(meas_count), 40'd0);
        tick(1'b0, 40'd0);

        // One run of the default-parameter instance.
        seen = -1;
        dmax = 40'sd0;
        start_d = 1'b1;
        tick(1'b0, rnd40());
        start_d = 1'b0;
        e_d = cyc;
        for (int i = 0; i < 3000; i++) begin
            int sc_d;
            sc_d = cyc - e_d + 1;
            if (done_d === 1'b1) begin
                seen = sc_d;
                break;
            end
            d = rnd40();
            if (sc_d == 171) dmax = d;
            else if ((sc_d > 171) && (sc_d <= 2171) && ($signed(d) > dmax)) dmax = d;
            tick(1'b0, d);
        end
        chk("dflt_done_cycle", 40'(seen), 40'd2172);
        chk("dflt_peak", peak_d, dmax);
        chk("dflt_count", 40'(cnt_d), 40'd1);
        chk("dflt_busy_at_done", 40'(busy_d), 40'd1);
        tick(1'b0, 40'd0);
        chk("dflt_idle_after", 40'(busy_d), 40'd0);
        chk("dflt_done_pulse", 40'(done_d), 40'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
